// File: rtl/conv1_win_ctrl.sv
// ============================================================================
// Module   : conv1_win_ctrl
// Brief    : Raster pixel sequencer for the 5x5 first-stage convolution window.
//            Optional stall counter enabled by CONV1_WIN_CTRL_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv1_win_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          buf_shift_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
`ifdef CONV1_WIN_CTRL_STALL_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          frame_done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [CW-1:0] c_km1      = CW'(K - 1);
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_row_last = CW'(IMG_H - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          frame_done_q, frame_done_d;

    logic w_accept;
    logic w_last_pix;
    logic w_win_hit;

    // A held window may be consumed in the same cycle a new pixel is accepted.
    assign pix_ready    = (state_q == c_st_run) & (~win_valid_q | win_ready);
    assign w_accept     = pix_valid & pix_ready;
    assign buf_shift_en = w_accept;
    assign w_last_pix   = (row_q == c_row_last) & (col_q == c_col_last);
    assign w_win_hit    = (row_q >= c_km1) & (col_q >= c_km1);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (start) begin
                    state_d = c_st_run;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            c_st_run: begin
                if (w_accept && w_last_pix) begin
                    state_d = c_st_drain;
                end
            end
            c_st_drain: begin
                if (win_valid_q && win_ready) begin
                    state_d      = c_st_idle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = c_st_idle;
        endcase

        if (w_accept) begin
            if (col_q == c_col_last) begin
                col_d = '0;
                row_d = (row_q == c_row_last) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // The window for a pixel is complete once its bottom-right tap arrives.
        if (w_accept && w_win_hit) begin
            win_valid_d = 1'b1;
            out_row_d   = row_q - c_km1;
            out_col_d   = col_q - c_km1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= c_st_idle;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == c_st_run) | (state_q == c_st_drain);

`ifdef CONV1_WIN_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == c_st_idle) && start) begin
            stall_cnt_d = '0;
        end else if (win_valid_q && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
